// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALU op codes and the
// bubble constant used by every stage register.
package pipe_pkg;

  localparam int CTRL_W = 12;

  // Single-bit control flags, LSB first.
  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_REG_WRITE = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_JUMP      = 4;
  localparam int CTRL_ALU_SRC   = 5;

  // ALU operation field occupies the upper bits of the bundle.
  localparam int CTRL_ALU_OP_LSB = 6;
  localparam int CTRL_ALU_OP_W   = 6;

  typedef enum logic [CTRL_ALU_OP_W-1:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_AND  = 6'd2,
    ALU_OR   = 6'd3,
    ALU_XOR  = 6'd4,
    ALU_SLL  = 6'd5,
    ALU_SRL  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_SLT  = 6'd8,
    ALU_SLTU = 6'd9
  } alu_op_e;

  // Packed view of the bundle; field order matches the bit indices above.
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    jump;
    logic    branch;
    logic    reg_write;
    logic    mem_write;
    logic    mem_read;
  } ctrl_t;

  // A bubble carries no side effects: every control bit is clear.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // True when the bundle describes a load.
  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load still sitting in the following stage.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic [4:0] id_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  logic rs1_match;
  logic rs2_match;

  // Source matches only count when the instruction really reads that port;
  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  // NOTE: every signal driven from always_comb gets a default first so no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    load_use  = 1'b0;
    if (ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid) begin
      rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
      load_use  = rs1_match || rs2_match;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_W     = pipe_pkg::CTRL_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [DATA_WIDTH-1:0] id_rd_data1,
  input  logic [DATA_WIDTH-1:0] id_rd_data2,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [DATA_WIDTH-1:0] ex_op1,
  output logic [DATA_WIDTH-1:0] ex_op2,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  hazard_stall,
  output logic [CNT_W-1:0]      bubble_cnt
);

  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic load_use;
  logic insert_bubble;
  logic count_bubble;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_uses_rs1 (id_uses_rs1),
    .id_rs1      (id_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  // A flush kills the incoming instruction anyway, so IF/ID need not hold.
  assign hazard_stall = load_use && !flush_i;

  // Either a flush or a load-use hazard replaces the captured instruction
  // with a bubble; only the hazard case is counted.
  assign insert_bubble = flush_i || load_use;
  assign count_bubble  = load_use && !flush_i && !hold_i;

  // EX register: reset, then hold, then bubble, else capture from ID.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= CTRL_W'(CTRL_BUBBLE);
    end else if (hold_i) begin
      // Downstream stall: every field keeps its value.
    end else if (insert_bubble) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= CTRL_W'(CTRL_BUBBLE);
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_imm   <= id_imm;
      ex_op1   <= id_rd_data1;
      ex_op2   <= id_rd_data2;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      // An invalid slot must not carry control bits that could cause writes.
      ex_ctrl  <= id_valid ? id_ctrl : CTRL_W'(CTRL_BUBBLE);
    end
  end

  // Saturating count of load-use bubbles actually inserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (count_bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors, a behavioural
// reference model compared every cycle, and literal spot checks.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int DW    = 32;
  localparam int CW    = pipe_pkg::CTRL_W;
  localparam int CNT_W = 4;
  localparam int CNT_MAXV = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic [DW-1:0] id_imm;
  logic [CW-1:0] id_ctrl;
  logic [DW-1:0] id_rd_data1, id_rd_data2;
  logic          flush_i, hold_i;
  logic          ex_valid;
  logic [DW-1:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic          hazard_stall;
  logic [CNT_W-1:0] bubble_cnt;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.DATA_WIDTH(DW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2),
    .flush_i(flush_i), .hold_i(hold_i), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    logic [DW-1:0] pc, imm, op1, op2;
    logic [4:0]  rs1, rs2, rd;
    logic [CW-1:0] ctrl;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;
  bit  model_ok = 0;

  function automatic bit model_load_use();
    if (!m_ex.valid || !m_ex.ctrl[CTRL_MEM_READ] || m_ex.rd == 0 || !id_valid) return 0;
    return (id_uses_rs1 && id_rs1 == m_ex.rd) || (id_uses_rs2 && id_rs2 == m_ex.rd);
  endfunction

  function automatic ex_t empty_slot();
    ex_t e;
    e.valid = 0; e.pc = '0; e.imm = '0; e.op1 = '0; e.op2 = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctrl = '0;
    return e;
  endfunction

  always @(posedge clk) begin
    bit lu;
    lu = model_load_use();
    if (!rst_n) begin
      m_ex = empty_slot();
      m_cnt = 0;
      model_ok = 1;
    end else if (hold_i) begin
      // frozen
    end else if (flush_i) begin
      m_ex = empty_slot();
    end else if (lu) begin
      m_ex = empty_slot();
      if (m_cnt < CNT_MAXV) m_cnt = m_cnt + 1;
    end else begin
      m_ex.valid = id_valid;
      m_ex.pc = id_pc; m_ex.imm = id_imm;
      m_ex.op1 = id_rd_data1; m_ex.op2 = id_rd_data2;
      m_ex.rs1 = id_rs1; m_ex.rs2 = id_rs2; m_ex.rd = id_rd;
      m_ex.ctrl = id_valid ? id_ctrl : '0;
    end
  end

  // Compare process: DUT vs model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("ex_valid", 64'(ex_valid), 64'(m_ex.valid));
      check("ex_pc",    64'(ex_pc),    64'(m_ex.pc));
      check("ex_imm",   64'(ex_imm),   64'(m_ex.imm));
      check("ex_op1",   64'(ex_op1),   64'(m_ex.op1));
      check("ex_op2",   64'(ex_op2),   64'(m_ex.op2));
      check("ex_rs1",   64'(ex_rs1),   64'(m_ex.rs1));
      check("ex_rs2",   64'(ex_rs2),   64'(m_ex.rs2));
      check("ex_rd",    64'(ex_rd),    64'(m_ex.rd));
      check("ex_ctrl",  64'(ex_ctrl),  64'(m_ex.ctrl));
      check("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
      check("hazard_stall", 64'(hazard_stall), 64'(model_load_use() && !flush_i));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [CW-1:0] mk_ctrl(input bit load, input alu_op_e op);
    ctrl_t c;
    c = '0;
    c.mem_read  = load;
    c.reg_write = 1'b1;
    c.alu_src   = load;
    c.alu_op    = op;
    return c;
  endfunction

  task automatic set_id(input bit v, input logic [DW-1:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input bit u1,
                        input bit u2, input logic [DW-1:0] imm, input logic [CW-1:0] ctrl,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_imm = imm; id_ctrl = ctrl;
    id_rd_data1 = d1; id_rd_data2 = d2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [DW-1:0] pc);
    set_id(1, pc, 5'd1, 5'd0, rd, 0, 0, 32'h4, mk_ctrl(1, ALU_ADD), 32'h1000, 32'h0);
  endtask

  task automatic set_add_rs1(input logic [4:0] r1, input logic [DW-1:0] pc);
    set_id(1, pc, r1, 5'd2, 5'd8, 1, 1, 32'h0, mk_ctrl(0, ALU_ADD), 32'h11, 32'h22);
  endtask

  logic [CW-1:0] add_ctrl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add_ctrl = mk_ctrl(0, ALU_ADD);
    rst_n = 0; flush_i = 0; hold_i = 0;
    set_id(1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1,
           $urandom, CW'($urandom), $urandom, $urandom);
    tick(); tick();
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
    check("rst_cnt", 64'(bubble_cnt), 64'd0);

    // Plain capture right after release.
    rst_n = 1;
    set_id(1, 32'h100, 5'd5, 5'd6, 5'd7, 1, 1, 32'h10, add_ctrl, 32'hDEADBEEF, 32'h12345678);
    @(negedge clk);
    check("cap_stall_pre", 64'(hazard_stall), 64'd0);
    tick();
    @(negedge clk);
    check("cap_pc", 64'(ex_pc), 64'h100);
    check("cap_op1", 64'(ex_op1), 64'hDEADBEEF);
    check("cap_rd", 64'(ex_rd), 64'd7);
    check("cap_valid", 64'(ex_valid), 64'd1);
    check("cap_stall", 64'(hazard_stall), 64'd0);

    // Load-use: one-cycle stall, one bubble, then the add enters EX.
    set_load(5'd5, 32'h104);
    tick();
    set_add_rs1(5'd5, 32'h108);
    @(negedge clk);
    check("lu_stall", 64'(hazard_stall), 64'd1);
    tick();
    @(negedge clk);
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_stall_gone", 64'(hazard_stall), 64'd0);
    check("lu_cnt", 64'(bubble_cnt), 64'd1);
    tick();
    @(negedge clk);
    check("lu_add_valid", 64'(ex_valid), 64'd1);
    check("lu_add_pc", 64'(ex_pc), 64'h108);

    // Load to x0 then a use of x0: no stall.
    set_load(5'd0, 32'h10C);
    tick();
    set_add_rs1(5'd0, 32'h110);
    @(negedge clk);
    check("x0_no_stall", 64'(hazard_stall), 64'd0);
    tick();

    // Load rd=5, consumer has rs2=5 but does not read rs2.
    set_load(5'd5, 32'h114);
    tick();
    set_id(1, 32'h118, 5'd3, 5'd5, 5'd9, 1, 0, 32'h0, add_ctrl, 32'h3, 32'h5);
    @(negedge clk);
    check("unused_rs2_no_stall", 64'(hazard_stall), 64'd0);
    tick();

    // rs2 hazard that is real.
    set_load(5'd6, 32'h11C);
    tick();
    set_id(1, 32'h120, 5'd3, 5'd6, 5'd9, 1, 1, 32'h0, add_ctrl, 32'h3, 32'h6);
    @(negedge clk);
    check("rs2_stall", 64'(hazard_stall), 64'd1);
    tick();
    check("rs2_cnt", 64'(bubble_cnt), 64'd2);
    tick();

    // Flush coincident with load-use: flush wins, counter unchanged.
    set_load(5'd5, 32'h124);
    tick();
    set_add_rs1(5'd5, 32'h128);
    flush_i = 1;
    @(negedge clk);
    check("flush_lu_stall", 64'(hazard_stall), 64'd0);
    tick();
    flush_i = 0;
    @(negedge clk);
    check("flush_lu_valid", 64'(ex_valid), 64'd0);
    check("flush_lu_cnt", 64'(bubble_cnt), 64'd2);

    // Flush alone on a valid instruction.
    set_add_rs1(5'd4, 32'h12C);
    flush_i = 1;
    tick();
    flush_i = 0;
    @(negedge clk);
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_ctrl", 64'(ex_ctrl), 64'd0);

    // Invalid slot captured: control forced to zero.
    set_id(0, 32'h130, 5'd1, 5'd2, 5'd3, 1, 1, 32'h7, mk_ctrl(1, ALU_SUB), 32'h1, 32'h2);
    tick();
    @(negedge clk);
    check("inval_ctrl", 64'(ex_ctrl), 64'd0);
    check("inval_pc", 64'(ex_pc), 64'h130);

    // Hold for 3 cycles with changing inputs, also with flush asserted.
    set_id(1, 32'h200, 5'd10, 5'd11, 5'd12, 1, 1, 32'h20, add_ctrl, 32'hA, 32'hB);
    tick();
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h300 + 32'(i), 5'(i), 5'(i + 1), 5'(i + 2), 1, 1, 32'(i),
             add_ctrl, 32'(i), 32'(i));
      flush_i = (i == 2);
      tick();
      @(negedge clk);
      check("hold_pc", 64'(ex_pc), 64'h200);
      check("hold_rd", 64'(ex_rd), 64'd12);
    end
    hold_i = 0;
    tick();
    flush_i = 0;
    check("hold_flush_after", 64'(ex_valid), 64'd0);

    // Saturation: keep inserting load-use bubbles past the counter limit.
    for (int i = 0; i < CNT_MAXV + 4; i++) begin
      set_load(5'd5, 32'h400);
      tick();
      set_add_rs1(5'd5, 32'h404);
      tick();
    end
    @(negedge clk);
    check("sat_cnt", 64'(bubble_cnt), 64'(CNT_MAXV));

    // Reset mid-operation discards the in-flight instruction.
    set_load(5'd7, 32'h500);
    tick();
    rst_n = 0;
    tick();
    @(negedge clk);
    check("midrst_valid", 64'(ex_valid), 64'd0);
    check("midrst_cnt", 64'(bubble_cnt), 64'd0);
    rst_n = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (register-file read) and execute.
- Captures the register-file read data, decoded fields and control bundle into the EX stage.
- Detects load-use hazards against the instruction currently in EX, inserts one bubble and tells IF/ID to hold.
- Honours branch-mispredict flush and downstream hold, and counts inserted bubbles for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of PC, immediate and operand data.
- CTRL_W, 12, width of the decoded control bundle.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_pc  in  DATA_WIDTH  PC of the decode instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register addresses.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_rd_data1, id_rd_data2  in  DATA_WIDTH  register-file read data; x0 already reads 0.
- flush_i  in  1  branch mispredict; kill the instruction entering EX.
- hold_i  in  1  downstream stall; freeze the EX register.
- ex_valid  out  1  EX stage holds a valid instruction.
- ex_pc, ex_imm, ex_op1, ex_op2  out  DATA_WIDTH each  registered fields.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered addresses, for the forwarding unit.
- ex_ctrl  out  CTRL_W  registered control bundle.
- hazard_stall  out  1  combinational; IF/ID must hold this cycle.
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (rst_n low at a clock edge):
  - all ex_* outputs are 0, including ex_valid=0; bubble_cnt=0.
  - Reset mid-operation discards any in-flight instruction.
- Load-use condition:
  - load_use = ex_valid & ex_ctrl[CTRL_MEM_READ] & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Stall output: hazard_stall = load_use & ~flush_i. It is a pure function of the registered EX state and current inputs, with zero latency.
- Per-edge update, in priority order:
  - 1. rst_n=0: reset.
  - 2. hold_i=1: all EX registers and bubble_cnt hold. hold_i takes precedence over flush_i; the flush source must keep flush_i asserted until hold_i drops.
  - 3. flush_i=1: bubble. ex_valid=0, ex_ctrl=0, ex_rd=0; the other fields are don't-care and are cleared to 0. bubble_cnt does not increment.
  - 4. load_use=1: bubble as above, and bubble_cnt increments, saturating at all-ones.
  - 5. Otherwise: capture. ex_valid=id_valid, plus all id_* fields; ex_op1=id_rd_data1, ex_op2=id_rd_data2.
  - If id_valid=0 on capture, ex_ctrl is forced to 0 so no side effects escape.
- Stall length: a load-use stall lasts exactly one cycle. After the bubble, ex_valid=0, so load_use deasserts. The held decode instruction then re-reads the register file and captures normally.
- No writeback bypass in this block: the register file writes on the negative edge, so same-cycle reads already return the written value. Forwarding from MEM/WB into EX belongs to the forwarding unit, which is driven by ex_rs1/ex_rs2.
- x0 handling:
  - ex_rd=0 never raises load_use.
  - A load to x0 followed by a use of x0 does not stall.
- Simultaneous flush_i and load_use: flush wins, hazard_stall=0, counter unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W;
  - control bit indices CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_REG_WRITE, CTRL_BRANCH, CTRL_JUMP, CTRL_ALU_SRC and the ALU-op field;
  - the constant CTRL_BUBBLE (all zeros).
- Sub-module hazard_detect is natural: it is purely combinational and computes load_use from the EX and ID fields. It is reused by the future EX/MEM stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1 and random fields -> ex_valid=0, ex_ctrl=0, bubble_cnt=0. After release, the first capture occurs on the next edge.
- Plain capture: id_pc=0x100, rs1=5, rs2=6, rd=7, rd_data1=0xDEADBEEF, imm=0x10 -> the next cycle shows ex_pc=0x100, ex_op1=0xDEADBEEF, ex_rd=7, ex_valid=1, and hazard_stall=0 throughout.
- Load-use: a load with rd=5 in EX, then ID with add using rs1=5 -> hazard_stall=1 for exactly one cycle; the next EX is a bubble (ex_valid=0); the add enters EX one cycle later; bubble_cnt=1.
- x0 and unused source: a load with rd=0, then a use of rs1=0 -> no stall. A load with rd=5, then an instruction with id_uses_rs2=0 and id_rs2=5 -> no stall.
- Flush versus load-use: a load-use condition with flush_i=1 in the same cycle -> hazard_stall=0, EX bubble, bubble_cnt unchanged. flush_i alone -> ex_valid=0 on the next edge.
- Hold and saturation: hold_i=1 for 3 cycles with changing id_* inputs -> EX outputs are frozen. Preload bubble_cnt to 0xFFFF via repeated load-use -> it stays at 0xFFFF.
